// File: rtl/sram_arbiter_if.sv
// Bus bundle between requesters, the arbiter and the single-port SRAM.
//
// Handshake: a command on requester i transfers in a cycle where
// req_valid[i] and req_ready[i] are both high on the rising clock edge. Once
// req_valid[i] is raised, the requester keeps req_valid/req_we/req_addr/req_wdata
// for that slot unchanged until the transfer. req_ready is one-hot or zero and
// never depends on its own value. rsp_valid is a one-cycle strobe with no
// back-pressure. The memory side is a plain enable/write-enable SRAM port.
//
// The arbiter uses the slave modport. The requester/memory environment uses
// the master modport.
interface sram_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8
);
    // requester command side
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;

    // requester response side
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_rdata;

    // SRAM port
    logic                      mem_en;
    logic                      mem_we;
    logic [ADDR_W-1:0]         mem_addr;
    logic [DATA_W-1:0]         mem_wdata;
    logic [DATA_W-1:0]         mem_rdata;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/sram_arbiter.sv
// Round-robin arbiter that shares one single-port synchronous SRAM between
// NUM_REQ requesters. It accepts up to one command per cycle, issues it to
// the SRAM one cycle later, and returns read data to the originating
// requester through a two-stage {valid, index} tag pipeline. Read latency
// from acceptance to rsp_valid is a fixed 3 cycles. Writes produce no
// response.
module sram_arbiter #(
    parameter int  NUM_REQ = 2,
    parameter int  ADDR_W  = 8,
    parameter int  DATA_W  = 8,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic              clk,
    input  logic              reset_n,
    sram_arbiter_if.slave     bus,
    // current round-robin pointer, for observation only
    output logic [IDX_W-1:0]  dbg_last_grant
);

    // ------------------------------------------------------------------
    // Arbitration state
    // ------------------------------------------------------------------
    logic [IDX_W-1:0]   last_grant_q, last_grant_d;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_found;
    logic [NUM_REQ-1:0] ready;
    logic               accept;

    // ------------------------------------------------------------------
    // SRAM issue registers
    // ------------------------------------------------------------------
    logic               mem_en_q, mem_en_d;
    logic               mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;

    // ------------------------------------------------------------------
    // Read tag pipeline: stage 1 lines up with mem_en, stage 2 with mem_rdata
    // ------------------------------------------------------------------
    logic               tag1_vld_q, tag1_vld_d;
    logic [IDX_W-1:0]   tag1_idx_q, tag1_idx_d;
    logic               tag2_vld_q, tag2_vld_d;
    logic [IDX_W-1:0]   tag2_idx_q, tag2_idx_d;

    // ------------------------------------------------------------------
    // Response registers
    // ------------------------------------------------------------------
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;

    // Round-robin search starting one past the last accepted requester.
    // The grant is gated by reset_n so that nothing is offered while the
    // block is held in reset.
    always_comb begin
        int cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        ready       = '0;
        cand        = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(last_grant_q) + k) % NUM_REQ;
            if (!grant_found && bus.req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = IDX_W'(cand);
            end
        end
        if (!reset_n) begin
            grant_found = 1'b0;
        end
        if (grant_found) begin
            ready[grant_idx] = 1'b1;
        end
    end

    // Ready is only ever offered to a valid requester, so a grant is an accept.
    assign accept        = grant_found;
    assign bus.req_ready = ready;

    // Pointer moves only on acceptance. It holds through idle cycles.
    always_comb begin
        last_grant_d = last_grant_q;
        if (accept) begin
            last_grant_d = grant_idx;
        end
    end

    // Register the accepted command onto the SRAM port for one cycle.
    // Address and write data hold their last values while idle.
    always_comb begin
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (accept) begin
            mem_en_d    = 1'b1;
            mem_we_d    = bus.req_we[grant_idx];
            mem_addr_d  = bus.req_addr[grant_idx*ADDR_W +: ADDR_W];
            mem_wdata_d = bus.req_wdata[grant_idx*DATA_W +: DATA_W];
        end
    end

    // Advance read tags alongside the SRAM access. Only reads enter.
    always_comb begin
        tag1_vld_d = accept && !bus.req_we[grant_idx];
        tag1_idx_d = accept ? grant_idx : tag1_idx_q;
        tag2_vld_d = tag1_vld_q;
        tag2_idx_d = tag1_idx_q;
    end

    // Capture SRAM read data one cycle after it is driven and strobe the owner.
    always_comb begin
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        if (tag2_vld_q) begin
            rsp_valid_d[tag2_idx_q] = 1'b1;
            rsp_rdata_d             = bus.mem_rdata;
        end
    end

    // Pointer register. Reset points at the last requester so requester 0
    // wins first.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= IDX_W'(NUM_REQ - 1);
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    // SRAM issue registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Tag pipeline. Reset drops in-flight reads so they never respond.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tag1_vld_q <= 1'b0;
            tag1_idx_q <= '0;
            tag2_vld_q <= 1'b0;
            tag2_idx_q <= '0;
        end else begin
            tag1_vld_q <= tag1_vld_d;
            tag1_idx_q <= tag1_idx_d;
            tag2_vld_q <= tag2_vld_d;
            tag2_idx_q <= tag2_idx_d;
        end
    end

    // Response registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign dbg_last_grant = last_grant_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with two requesters and a behavioural SRAM.
// Inputs change 1 time unit after the rising edge. Outputs are checked on
// the falling edge.
module tb_sram_arbiter;
  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 8;

  // clock / reset
  logic       clk = 1'b0;
  logic       reset_n;
  logic [0:0] dbg_last_grant;

  always #5 clk = ~clk;

  sram_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sram_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .bus            (bus),
    .dbg_last_grant (dbg_last_grant)
  );

  // behavioural single-port synchronous SRAM
  logic [DATA_W-1:0] mem [256];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= mem[bus.mem_addr];
    end
  end

  // scoreboard counters
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic we,
                         input logic [7:0] a, input logic [7:0] d);
    bus.req_valid[i]            = v;
    bus.req_we[i]               = we;
    bus.req_addr[i*ADDR_W +: ADDR_W]  = a;
    bus.req_wdata[i*DATA_W +: DATA_W] = d;
  endtask

  initial begin
    reset_n       = 1'b0;
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    // ---------------- reset with both requesting ----------------
    set_req(0, 1'b1, 1'b0, 8'h00, 8'h00);
    set_req(1, 1'b1, 1'b0, 8'h00, 8'h00);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rst_ready", bus.req_ready, 2'b00);
      check("rst_mem_en", bus.mem_en, 1'b0);
      check("rst_rsp_valid", bus.rsp_valid, 2'b00);
      step();
    end
    check("rst_mem_addr", bus.mem_addr, 8'h00);
    check("rst_mem_wdata", bus.mem_wdata, 8'h00);
    check("rst_rsp_rdata", bus.rsp_rdata, 8'h00);
    check("rst_ptr", dbg_last_grant, 1'b1);

    // release; preload 0x01=0x11 (req0) and 0x02=0x22 (req1)
    reset_n = 1'b1;
    set_req(0, 1'b1, 1'b1, 8'h01, 8'h11);
    set_req(1, 1'b1, 1'b1, 8'h02, 8'h22);
    @(negedge clk);
    check("first_grant", bus.req_ready, 2'b01);
    step();
    bus.req_valid[0] = 1'b0;
    @(negedge clk);
    check("pre_ready1", bus.req_ready, 2'b10);
    check("pre_en0", bus.mem_en, 1'b1);
    check("pre_we0", bus.mem_we, 1'b1);
    check("pre_addr0", bus.mem_addr, 8'h01);
    check("pre_wdata0", bus.mem_wdata, 8'h11);
    step();
    bus.req_valid[1] = 1'b0;
    @(negedge clk);
    check("pre_ready_none", bus.req_ready, 2'b00);
    check("pre_en1", bus.mem_en, 1'b1);
    check("pre_addr1", bus.mem_addr, 8'h02);
    check("pre_wdata1", bus.mem_wdata, 8'h22);
    step();
    @(negedge clk);
    check("idle_en", bus.mem_en, 1'b0);
    check("idle_addr_hold", bus.mem_addr, 8'h02);
    check("idle_wdata_hold", bus.mem_wdata, 8'h22);
    check("pre_ptr", dbg_last_grant, 1'b1);
    step();

    // ---------------- contention: both read for 6 cycles ----------------
    set_req(0, 1'b1, 1'b0, 8'h01, 8'h00);
    set_req(1, 1'b1, 1'b0, 8'h02, 8'h00);
    for (int k = 0; k < 10; k++) begin
      if (k == 6) bus.req_valid = '0;
      @(negedge clk);
      check("cont_ready", bus.req_ready, (k < 6) ? ((k % 2 == 0) ? 2'b01 : 2'b10) : 2'b00);
      check("cont_mem_en", bus.mem_en, (k >= 1 && k <= 6) ? 1'b1 : 1'b0);
      if (k >= 1 && k <= 6)
        check("cont_mem_addr", bus.mem_addr, (k % 2 == 1) ? 8'h01 : 8'h02);
      check("cont_rsp_valid", bus.rsp_valid,
            (k >= 3 && k <= 8) ? ((k % 2 == 1) ? 2'b01 : 2'b10) : 2'b00);
      if (k >= 3 && k <= 8)
        check("cont_rdata", bus.rsp_rdata, (k % 2 == 1) ? 8'h11 : 8'h22);
      step();
    end
    check("cont_ptr", dbg_last_grant, 1'b1);

    // ---------------- req0 write 0x10=0xA5 then read 0x10 ----------------
    set_req(0, 1'b1, 1'b1, 8'h10, 8'hA5);
    @(negedge clk);
    check("wr_ready", bus.req_ready, 2'b01);
    step();
    set_req(0, 1'b1, 1'b0, 8'h10, 8'h00);
    @(negedge clk);
    check("rd_ready", bus.req_ready, 2'b01);
    check("wr_c1_en", bus.mem_en, 1'b1);
    check("wr_c1_we", bus.mem_we, 1'b1);
    check("wr_c1_addr", bus.mem_addr, 8'h10);
    check("wr_c1_wdata", bus.mem_wdata, 8'hA5);
    step();
    bus.req_valid = '0;
    @(negedge clk);
    check("rd_c1_en", bus.mem_en, 1'b1);
    check("rd_c1_we", bus.mem_we, 1'b0);
    check("rd_c1_addr", bus.mem_addr, 8'h10);
    check("rd_c1_rsp", bus.rsp_valid, 2'b00);
    step();
    @(negedge clk);
    check("rd_c2_en", bus.mem_en, 1'b0);
    check("rd_c2_rsp", bus.rsp_valid, 2'b00);
    step();
    @(negedge clk);
    check("rd_c3_rsp", bus.rsp_valid, 2'b01);
    check("rd_c3_data", bus.rsp_rdata, 8'hA5);
    step();
    @(negedge clk);
    check("rd_c4_rsp", bus.rsp_valid, 2'b00);
    step();

    // ---------------- cross-requester ordering ----------------
    set_req(1, 1'b1, 1'b1, 8'h20, 8'h3C);
    @(negedge clk);
    check("x_wr_ready", bus.req_ready, 2'b10);
    step();
    bus.req_valid[1] = 1'b0;
    set_req(0, 1'b1, 1'b0, 8'h20, 8'h00);
    @(negedge clk);
    check("x_rd_ready", bus.req_ready, 2'b01);
    check("x_wr_we", bus.mem_we, 1'b1);
    check("x_wr_addr", bus.mem_addr, 8'h20);
    step();
    bus.req_valid = '0;
    @(negedge clk);
    check("x_rd_en", bus.mem_en, 1'b1);
    check("x_rd_we", bus.mem_we, 1'b0);
    step();
    @(negedge clk);
    check("x_c2_rsp", bus.rsp_valid, 2'b00);
    step();
    @(negedge clk);
    check("x_c3_rsp", bus.rsp_valid, 2'b01);
    check("x_c3_data", bus.rsp_rdata, 8'h3C);
    step();

    // ---------------- idle/hold after a grant to req1 ----------------
    set_req(1, 1'b1, 1'b1, 8'h30, 8'h77);
    @(negedge clk);
    check("h_ready", bus.req_ready, 2'b10);
    step();
    bus.req_valid = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("h_mem_en", bus.mem_en, (i == 0) ? 1'b1 : 1'b0);
      check("h_ready_idle", bus.req_ready, 2'b00);
      check("h_ptr", dbg_last_grant, 1'b1);
      step();
    end
    set_req(0, 1'b1, 1'b0, 8'h30, 8'h00);
    set_req(1, 1'b1, 1'b0, 8'h10, 8'h00);
    @(negedge clk);
    check("h_grant0", bus.req_ready, 2'b01);
    step();
    bus.req_valid[0] = 1'b0;
    @(negedge clk);
    check("h_grant1", bus.req_ready, 2'b10);
    step();
    bus.req_valid = '0;
    @(negedge clk);
    check("h_rsp_none", bus.rsp_valid, 2'b00);
    step();
    @(negedge clk);
    check("h_rsp0", bus.rsp_valid, 2'b01);
    check("h_data0", bus.rsp_rdata, 8'h77);
    step();
    @(negedge clk);
    check("h_rsp1", bus.rsp_valid, 2'b10);
    check("h_data1", bus.rsp_rdata, 8'hA5);
    step();
    @(negedge clk);
    check("h_rsp_end", bus.rsp_valid, 2'b00);
    check("h_ptr_end", dbg_last_grant, 1'b1);
    step();

    // ---------------- reset mid-flight ----------------
    set_req(0, 1'b1, 1'b0, 8'h01, 8'h00);
    set_req(1, 1'b1, 1'b0, 8'h02, 8'h00);
    @(negedge clk);
    check("mf_ready0", bus.req_ready, 2'b01);
    step();
    @(negedge clk);
    check("mf_ready1", bus.req_ready, 2'b10);
    step();
    reset_n = 1'b0;
    @(negedge clk);
    check("mf_rst_ready", bus.req_ready, 2'b00);
    check("mf_rst_en", bus.mem_en, 1'b0);
    check("mf_rst_rsp", bus.rsp_valid, 2'b00);
    check("mf_rst_ptr", dbg_last_grant, 1'b1);
    step();
    reset_n = 1'b1;
    set_req(0, 1'b1, 1'b1, 8'h40, 8'h01);
    set_req(1, 1'b1, 1'b1, 8'h41, 8'h02);
    @(negedge clk);
    check("mf_post_grant0", bus.req_ready, 2'b01);
    check("mf_post_rsp0", bus.rsp_valid, 2'b00);
    step();
    bus.req_valid[0] = 1'b0;
    @(negedge clk);
    check("mf_post_grant1", bus.req_ready, 2'b10);
    check("mf_post_rsp1", bus.rsp_valid, 2'b00);
    step();
    bus.req_valid = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mf_no_rsp", bus.rsp_valid, 2'b00);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Round-robin arbiter that shares one single-port synchronous SRAM (`sram_m`) between `NUM_REQ` requesters. Each requester issues read/write commands over a valid/ready handshake. The arbiter sequences accepted commands onto the SRAM port at up to one per cycle and routes read data back to the originating requester. It sits between the requester-side logic and the `sram_if` memory port.

## Interface
- `NUM_REQ`, default 2: number of requesters; legal range 2..4.
- `ADDR_W`, default 8: SRAM address width.
- `DATA_W`, default 8: SRAM data width.

Ports:
- `clk`  in  1: single clock; all logic is rising-edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ: per-requester command valid.
- `req_ready`  out  NUM_REQ: per-requester grant (combinational, one-hot or zero).
- `req_we`  in  NUM_REQ: per-requester write flag (1 = write).
- `req_addr`  in  NUM_REQ*ADDR_W: packed addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- `req_wdata`  in  NUM_REQ*DATA_W: packed write data, packed the same way.
- `rsp_valid`  out  NUM_REQ: one-hot read-response strobe.
- `rsp_rdata`  out  DATA_W: read data; meaningful only while `rsp_valid` is non-zero.
- `mem_en`  out  1: SRAM access enable.
- `mem_we`  out  1: SRAM write enable.
- `mem_addr`  out  ADDR_W: SRAM address.
- `mem_wdata`  out  DATA_W: SRAM write data.
- `mem_rdata`  in  DATA_W: SRAM read data, valid in the cycle after a read `mem_en`.

## Operation
- **Arbitration**
  - Combinational each cycle. Search starts at `last_grant+1` and wraps modulo `NUM_REQ`.
  - The first requester found with `req_valid` set gets `req_ready`.
  - At most one `req_ready` bit is high in any cycle.
- **Acceptance and pointer update**
  - A command is accepted when `req_valid[i] & req_ready[i]`.
  - `last_grant` updates to i only on acceptance. It holds when no request is valid.
- **Requester rules**
  - A requester must hold valid/we/addr/wdata stable until accepted.
  - The arbiter never withdraws `req_ready` from a valid requester within the same cycle.
- **Issue to SRAM**
  - An accepted command is registered onto `mem_en`/`mem_we`/`mem_addr`/`mem_wdata` for exactly one cycle.
  - `mem_en` = 0 in cycles with no accepted command. `mem_addr`/`mem_wdata` hold their last values when idle.
- **Read tag pipeline**
  - Each read carries a 2-stage tag pipeline: {valid, requester index}.
  - Writes produce no response.
- **Read return**
  - `mem_rdata` is captured into `rsp_rdata` the cycle after the SRAM drives it.
  - `rsp_valid[idx]` pulses for 1 cycle with the captured data.
- **Throughput and fairness**
  - Throughput is one command per cycle with no bubbles; the SRAM never stalls.
  - Fairness: with all requesters continuously valid, grants rotate 0,1,..,NUM_REQ-1,0,...
  - Wait bound: no requester waits more than NUM_REQ-1 cycles.
- **Ordering**
  - Write followed by read to the same address, from any requesters, in consecutive acceptances returns the new data.
  - This follows from in-order issue; no forwarding logic is needed.

## Timing
- **Reset values** (asynchronous on `reset_n` low):
  - `mem_en`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - `rsp_valid`=0, `rsp_rdata`=0.
  - Tag pipeline cleared.
  - `last_grant`=NUM_REQ-1, so requester 0 has first priority.
- **During reset:** `req_ready`=0 while `reset_n` is low.
- **Read latency**, with acceptance in cycle C0:
  - C1: `mem_en`=1, `mem_we`=0.
  - C2: SRAM drives `mem_rdata`.
  - C3: `rsp_valid[i]`=1 and `rsp_rdata` valid.
  - Fixed latency is 3 cycles.
- **Write latency:** `mem_en`=`mem_we`=1 in C1. The SRAM array updates at the end of C1.
- **Reset mid-operation:** in-flight reads are discarded and no `rsp_valid` is emitted for them. Arbitration restarts at requester 0 on the first cycle after `reset_n` rises.
- **Back-to-back reads:** reads accepted in consecutive cycles produce `rsp_valid` in consecutive cycles, in acceptance order.
- **Out-of-range index:** `NUM_REQ` bits above actual requesters never exist; the index width is $clog2(NUM_REQ).

## Test plan
- **Reset:** hold `reset_n`=0 for 3 clocks with `req_valid`=2'b11 -> `req_ready`=0 and `mem_en`=0 throughout. First grant after release goes to requester 0.
- **Single write then read:** req0 writes addr 0x10 data 0xA5, then req0 reads 0x10 -> `mem_en` pulses in C1 of each command. `rsp_valid`=2'b01 with `rsp_rdata`=0xA5 exactly 3 cycles after read acceptance.
- **Contention:** both requesters hold reads to 0x01 (req0) and 0x02 (req1), preloaded with 0x11 and 0x22, for 6 cycles.
  - Grants alternate 0,1,0,1,...
  - `rsp_valid` alternates 01,10 with data 0x11,0x22.
  - No idle cycles.
- **Cross-requester ordering:** req1 writes 0x20=0x3C, and req0 reads 0x20 accepted the next cycle -> req0 receives 0x3C.
- **Reset mid-flight:** two reads accepted, then `reset_n` pulsed low for 1 cycle before their C3 -> no `rsp_valid` ever asserts for them. The pointer returns to requester-0 priority.
- **Idle/hold:** `req_valid`=0 for 5 cycles after a grant to req1, then both request -> `mem_en`=0 while idle. The next grant goes to req0 because the pointer held at 1.
